// File: rtl/bin_to_bcd_seq.sv
// Sequential 8-bit binary to 3-digit packed BCD converter (double dabble, one shift per clock).
// Optional BIN_TO_BCD_OVF_EN: registers an ovf flag when the result needs a hundreds digit.
module bin_to_bcd_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_bin,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] out_bcd,
   output logic        ovf,
   output logic [1:0]  dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   // in_ready is high only in IDLE (and never during reset); out_valid is high only in DONE.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [19:0] sr_q, sr_d, sr_adj;
   logic [3:0]  cnt_q, cnt_d;
   logic [11:0] res_q, res_d;
`ifdef BIN_TO_BCD_OVF_EN
   logic        ovf_q, ovf_d;
`endif

   // Add-3 correction on each BCD digit independently before the shift.
   always_comb begin
      sr_adj = sr_q;
      for (int i = 0; i < 3; i++) begin
         if (sr_q[8+4*i +: 4] >= 4'd5)
            sr_adj[8+4*i +: 4] = sr_q[8+4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
`ifdef BIN_TO_BCD_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               sr_d    = {12'h000, in_bin};
               cnt_d   = 4'd0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sr_d  = sr_adj << 1;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
               res_d   = sr_d[19:8];
`ifdef BIN_TO_BCD_OVF_EN
               ovf_d   = (sr_d[19:16] != 4'd0);
`endif
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         sr_q    <= 20'h00000;
         cnt_q   <= 4'd0;
         res_q   <= 12'h000;
`ifdef BIN_TO_BCD_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
`ifdef BIN_TO_BCD_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = (state_q == S_DONE);
   assign out_bcd   = res_q;
   assign dbg_state = state_q;
`ifdef BIN_TO_BCD_OVF_EN
   assign ovf       = ovf_q;
`else
   assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: vector table, full sweep, random values and
// hand-written sequences for backpressure, back-to-back accepts and mid-conversion reset.
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_bin;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_bcd;
   logic        ovf;
   logic [1:0]  dbg_state;

`ifdef BIN_TO_BCD_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   typedef struct {
      logic [7:0]  bin;
      logic [11:0] bcd;
      logic        ovf;
   } vec_t;

   vec_t        vecs[10];
   logic [12:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   bin_to_bcd_seq dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
      .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd), .ovf(ovf),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Reference: decimal digits by plain division, ovf = value above two digits.
   function automatic logic [12:0] model(input int v);
      logic [3:0] h, t, u;
      h = 4'((v / 100) % 10);
      t = 4'((v / 10) % 10);
      u = 4'(v % 10);
      return {OVF_ON && (v > 99), h, t, u};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic run_conv(input logic [7:0] v, input logic [12:0] exp);
      int lat;
      logic [12:0] e;
      in_bin   = v;
      in_valid = 1'b1;
      check("in_ready_idle", 32'(in_ready), 32'd1);
      @(posedge clk);
      exp_q.push_back(exp);
      @(negedge clk);
      in_valid = 1'b0;
      in_bin   = 8'($urandom_range(0, 255));
      lat = 0;
      while (!out_valid && lat < 20) begin
         if (in_ready) check("in_ready_busy", 32'(in_ready), 32'd0);
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'd8);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("result", {19'd0, ovf, out_bcd}, {19'd0, e});
      end else begin
         check("queue_empty", 32'd1, 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_after_hs", 32'(out_valid), 32'd0);
      check("bcd_held_after_hs", 32'(out_bcd), 32'(exp[11:0]));
   endtask

   initial begin
      int acc_cnt;
      int acc_t[2];
      int cyc;
      logic [7:0] v;
      vecs[0] = '{8'd0,   12'h000, 1'b0};
      vecs[1] = '{8'd9,   12'h009, 1'b0};
      vecs[2] = '{8'd10,  12'h010, 1'b0};
      vecs[3] = '{8'd99,  12'h099, 1'b0};
      vecs[4] = '{8'd100, 12'h100, OVF_ON};
      vecs[5] = '{8'd255, 12'h255, OVF_ON};
      vecs[6] = '{8'd173, 12'h173, OVF_ON};
      vecs[7] = '{8'd64,  12'h064, 1'b0};
      vecs[8] = '{8'd7,   12'h007, 1'b0};
      vecs[9] = '{8'd199, 12'h199, OVF_ON};

      rst = 1'b1; in_valid = 1'b0; in_bin = 8'd0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_bcd", 32'(out_bcd), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 10; i++) run_conv(vecs[i].bin, {vecs[i].ovf, vecs[i].bcd});
      for (int i = 0; i < 256; i++) run_conv(8'(i), model(i));
      for (int i = 0; i < 40; i++) begin
         v = 8'($urandom);
         run_conv(v, model(int'(v)));
      end

      // Backpressure: hold DONE for 5 cycles while a new request waits.
      in_bin = 8'd173; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
      check("bp_latency", 32'(cyc), 32'd8);
      in_valid = 1'b1; in_bin = 8'd42;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_bcd", 32'(out_bcd), 32'h173);
         check("bp_ovf", 32'(ovf), 32'(OVF_ON));
         check("bp_no_accept", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_hs_done", 32'(out_valid), 32'd0);
      check("bp_idle", 32'(in_ready), 32'd1);
      check("bp_bcd_kept", 32'(out_bcd), 32'h173);
      repeat (3) @(negedge clk);
      check("bp_still_idle", 32'(out_valid), 32'd0);

      // Back-to-back with in_valid held high and out_ready tied high.
      in_bin = 8'd64; in_valid = 1'b1; out_ready = 1'b1;
      acc_cnt = 0; cyc = 0;
      exp_q.delete();
      while (acc_cnt < 2 && cyc < 40) begin
         if (out_valid) check("b2b_result", {19'd0, ovf, out_bcd}, {19'd0, exp_q.pop_front()});
         if (in_ready && in_valid) begin
            acc_t[acc_cnt] = cyc;
            exp_q.push_back(model(int'(in_bin)));
            acc_cnt++;
         end
         @(negedge clk);
         cyc++;
         if (acc_cnt == 1) in_bin = 8'd7;
      end
      check("b2b_accepts", 32'(acc_cnt), 32'd2);
      check("b2b_interval", 32'(acc_t[1] - acc_t[0]), 32'd10);
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
      check("b2b_second_done", 32'(out_valid), 32'd1);
      check("b2b_second", {19'd0, ovf, out_bcd}, {19'd0, exp_q.pop_front()});
      @(negedge clk);
      out_ready = 1'b0;

      // Reset during the 4th shift of 200.
      in_bin = 8'd200; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_out_bcd", 32'(out_bcd), 32'd0);
      check("abort_ovf", 32'(ovf), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort_idle", 32'(in_ready), 32'd1);
      run_conv(8'd19, 13'h0019);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
